ulpi_reg_access: RTL and testbench
==================================

ULPI_REG_ACCESS -- requirements
Module: ulpi_reg_access

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named i_clk and i_rst; all state SHALL update on the rising edge of i_clk.
REQ-002 Parameter: RETRY_MAX, default 3, max aborted attempts before failing a request.
REQ-003 Parameter: TIMEOUT_CYCLES, default 255, max cycles a request may stay outside IDLE.
REQ-004 Ports (name  direction  width  meaning):
- i_clk  in  1  ULPI 60 MHz clock
- i_rst  in  1  async reset, active high
- i_req  in  1  register access request, level, sampled in IDLE
- i_we  in  1  1 = write, 0 = read
- i_addr  in  6  ULPI immediate register address
- i_wdata  in  8  write data
- o_busy  out  1  request in progress
- o_ack  out  1  one-cycle completion pulse
- o_err  out  1  completion status, valid with o_ack
- o_rdata  out  8  read data, valid with o_ack on a read
- i_dir  in  1  ULPI dir from PHY
- i_nxt  in  1  ULPI nxt from PHY
- o_stp  out  1  ULPI stp
- i_data  in  8  ULPI data from PHY
- o_data  out  8  ULPI data to PHY
- o_data_oe  out  1  link drives ULPI data bus

Function
REQ-005 States SHALL be: IDLE, WR_CMD, WR_DATA, WR_STP, RD_CMD, RD_TURN1, RD_DATA, RD_TURN2, ABORT, DONE.
REQ-006 IDLE: when i_req=1 and i_dir=0, the block SHALL latch i_we/i_addr/i_wdata, clear the retry and timeout counters and go to WR_CMD (i_we=1) or RD_CMD (i_we=0); i_req with i_dir=1 SHALL be held off.
REQ-007 o_busy SHALL be 1 in every state except IDLE.
REQ-008 WR_CMD: o_data={2'b10,addr}; on i_nxt=1 go to WR_DATA.
REQ-009 WR_DATA: o_data=wdata; on i_nxt=1 go to WR_STP.
REQ-010 WR_STP: o_stp=1, o_data=8'h00 for exactly one cycle, then DONE.
REQ-011 RD_CMD: o_data={2'b11,addr}; on i_nxt=1 go to RD_TURN1.
REQ-012 RD_TURN1: o_data_oe=0; on i_dir=1 go to RD_DATA.
REQ-013 RD_DATA: capture i_data into o_rdata, then RD_TURN2.
REQ-014 RD_TURN2: wait for i_dir=0, then DONE.
REQ-015 DONE: o_ack=1 for one cycle, then IDLE; o_err=1 only on retry exhaustion or timeout.
REQ-016 o_data_oe SHALL be 1 in WR_CMD, WR_DATA, WR_STP and RD_CMD and combinationally forced to 0 whenever i_dir=1; o_data SHALL be 8'h00 when not driving.
REQ-017 Abort: i_dir=1 sampled in WR_CMD, WR_DATA or RD_CMD SHALL go to ABORT and increment the retry counter; i_dir=1 in WR_STP SHALL NOT abort.
REQ-018 ABORT: wait for i_dir=0, then restart at WR_CMD or RD_CMD; if the retry count exceeds RETRY_MAX, go to DONE with o_err=1.
REQ-019 The timeout counter SHALL count every non-IDLE cycle; reaching TIMEOUT_CYCLES SHALL force DONE with o_err=1 from any state.
REQ-020 Simultaneous i_nxt=1 and i_dir=1 in a CMD/DATA state SHALL be treated as an abort.
REQ-021 i_req while busy SHALL be ignored; a new request SHALL only be accepted in IDLE.

Reset
REQ-022 While i_rst=1: state=IDLE, o_busy=0, o_ack=0, o_err=0, o_rdata=8'h00, o_stp=0, o_data=8'h00, o_data_oe=0, counters cleared.
REQ-023 Reset asserted mid-transaction SHALL abandon it without an o_ack pulse; the first request after deassertion SHALL proceed normally.

Verification
REQ-024 Write addr=6'h0A, wdata=8'h55, i_nxt=1 after one cycle in each phase -> o_data 8'h8A then 8'h55; o_stp pulse with o_data=8'h00; o_ack=1, o_err=0.
REQ-025 Read addr=6'h16: i_nxt=1 on CMD, i_dir=1 next cycle, i_data=8'hA5, then i_dir=0 -> o_data=8'hD6 during CMD; o_rdata=8'hA5; o_ack=1, o_err=0.
REQ-026 Write with i_dir=1 in WR_DATA, then i_dir=0 -> o_data_oe=0 in the same cycle; command reissued as 8'h8A; completes with o_err=0.
REQ-027 i_dir held 1 across 4 consecutive attempts with RETRY_MAX=3 -> o_ack=1, o_err=1, no o_stp pulse.
REQ-028 Read with i_nxt stuck 0, TIMEOUT_CYCLES=16 -> o_ack=1, o_err=1 after 16 busy cycles; then o_data_oe=0.
REQ-029 i_rst=1 asserted in WR_DATA -> all outputs at reset values immediately; no o_ack; next write completes normally.

Source files
------------

// File: rtl/ulpi_reg_access.sv
// ULPI immediate register read/write engine: issues TX CMD / data / STP to the PHY,
// handles turnaround on reads, retries on PHY bus takeover and enforces a per-request timeout.
//
// state    | meaning
// IDLE     | waiting for a request while the PHY does not own the bus
// WR_CMD   | driving register-write command, waiting for nxt
// WR_DATA  | driving write data, waiting for nxt
// WR_STP   | one-cycle stp with idle data
// RD_CMD   | driving register-read command, waiting for nxt
// RD_TURN1 | bus released, waiting for PHY to take dir
// RD_DATA  | capturing register data from the PHY
// RD_TURN2 | waiting for PHY to release dir
// ABORT    | PHY took the bus mid-command, waiting to retry
// DONE     | one-cycle completion with status
module ulpi_reg_access #(
  parameter int RETRY_MAX      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [5:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_busy,
  output logic       o_ack,
  output logic       o_err,
  output logic [7:0] o_rdata,
  input  logic       i_dir,
  input  logic       i_nxt,
  output logic       o_stp,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_data_oe
);

  localparam int RW = $clog2(RETRY_MAX + 2);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [3:0] {
    IDLE, WR_CMD, WR_DATA, WR_STP, RD_CMD, RD_TURN1, RD_DATA, RD_TURN2, ABORT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [5:0]    addr_q;
  logic [7:0]    wdata_q;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          accept;
  logic          drive;
  logic [7:0]    tx_byte;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= 6'h00;
      wdata_q <= 8'h00;
      retry_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        we_q    <= i_we;
        addr_q  <= i_addr;
        wdata_q <= i_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    accept  = 1'b0;

    // Down-counting timeout over every cycle spent between acceptance and DONE
    if (state_q != IDLE && state_q != DONE && tmo_q != '0)
      tmo_d = tmo_q - TW'(1);

    case (state_q)
      IDLE: begin
        if (i_req && !i_dir) begin
          accept  = 1'b1;
          retry_d = '0;
          tmo_d   = TW'(TIMEOUT_CYCLES - 1);
          err_d   = 1'b0;
          state_d = i_we ? WR_CMD : RD_CMD;
        end
      end
      WR_CMD, WR_DATA, RD_CMD: begin
        if (i_dir) begin
          state_d = ABORT;
          retry_d = retry_q + RW'(1);
        end else if (i_nxt) begin
          case (state_q)
            WR_CMD:  state_d = WR_DATA;
            WR_DATA: state_d = WR_STP;
            default: state_d = RD_TURN1;
          endcase
        end
      end
      WR_STP:   state_d = DONE;
      RD_TURN1: if (i_dir) state_d = RD_DATA;
      RD_DATA: begin
        rdata_d = i_data;
        state_d = RD_TURN2;
      end
      RD_TURN2: if (!i_dir) state_d = DONE;
      ABORT: begin
        // Exhaustion does not need the bus back, so fail without waiting on dir
        if (retry_q > RW'(RETRY_MAX)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (!i_dir) begin
          state_d = we_q ? WR_CMD : RD_CMD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && state_q != DONE && tmo_q == '0) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
  end

  always_comb begin
    drive   = 1'b0;
    tx_byte = 8'h00;
    case (state_q)
      WR_CMD:  begin drive = 1'b1; tx_byte = {2'b10, addr_q}; end
      WR_DATA: begin drive = 1'b1; tx_byte = wdata_q;         end
      WR_STP:  begin drive = 1'b1; tx_byte = 8'h00;           end
      RD_CMD:  begin drive = 1'b1; tx_byte = {2'b11, addr_q}; end
      default: begin drive = 1'b0; tx_byte = 8'h00;           end
    endcase
  end

  // dir gates the output enable without a register so the link never fights the PHY
  assign o_data_oe = drive & ~i_dir;
  assign o_data    = o_data_oe ? tx_byte : 8'h00;
  assign o_stp     = (state_q == WR_STP);
  assign o_busy    = (state_q != IDLE);
  assign o_ack     = (state_q == DONE);
  assign o_err     = (state_q == DONE) & err_q;
  assign o_rdata   = rdata_q;

endmodule

// File: tb/tb_ulpi_reg_access.sv
// Directed bench for ulpi_reg_access: write, read, abort/retry, retry exhaustion,
// timeout and mid-transaction reset, all against hand-computed values.
module tb_ulpi_reg_access;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [5:0] addr = 6'h00;
  logic [7:0] wdata = 8'h00;
  logic       dir = 1'b0;
  logic       nxt = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       busy, ack, err, stp, data_oe;
  logic [7:0] rdata, data_out;

  int n_checks = 0;
  int n_errors = 0;

  ulpi_reg_access #(.RETRY_MAX(3), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_ack(ack), .o_err(err), .o_rdata(rdata),
    .i_dir(dir), .i_nxt(nxt), .o_stp(stp), .i_data(data_in),
    .o_data(data_out), .o_data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_ack"},  8'(ack),  8'd0);
    chk({tag, "_err"},  8'(err),  8'd0);
    chk({tag, "_stp"},  8'(stp),  8'd0);
    chk({tag, "_oe"},   8'(data_oe), 8'd0);
    chk({tag, "_data"}, data_out, 8'h00);
  endtask

  // Normal write with nxt arriving on the second cycle of each phase
  task automatic write_ok(input string tag, input logic [5:0] a, input logic [7:0] d);
    logic [7:0] cmd;
    cmd = {2'b10, a};
    req = 1'b1; we = 1'b1; addr = a; wdata = d; dir = 1'b0; nxt = 1'b0;
    step();
    // request inputs change while busy; latched values must be used
    we = 1'b0; addr = 6'h3F; wdata = 8'hFF;
    #1;
    chk({tag, "_cmd0"}, data_out, cmd);
    chk({tag, "_oe"}, 8'(data_oe), 8'd1);
    chk({tag, "_busy"}, 8'(busy), 8'd1);
    step(); nxt = 1'b1; #1;
    chk({tag, "_cmd1"}, data_out, cmd);
    step(); nxt = 1'b0; #1;
    chk({tag, "_wd0"}, data_out, d);
    step(); nxt = 1'b1; #1;
    chk({tag, "_wd1"}, data_out, d);
    step(); nxt = 1'b0; #1;
    chk({tag, "_stp"}, 8'(stp), 8'd1);
    chk({tag, "_stp_data"}, data_out, 8'h00);
    step(); req = 1'b0; #1;
    chk({tag, "_ack"}, 8'(ack), 8'd1);
    chk({tag, "_err"}, 8'(err), 8'd0);
    chk({tag, "_stp_gone"}, 8'(stp), 8'd0);
    step(); #1;
    chk({tag, "_ack_pulse"}, 8'(ack), 8'd0);
    chk({tag, "_idle"}, 8'(busy), 8'd0);
  endtask

  initial begin
    step(); step();
    chk_idle_outputs("rst");
    chk("rst_rdata", rdata, 8'h00);
    rst = 1'b0;
    step();

    // request held off while PHY owns the bus
    req = 1'b1; we = 1'b1; addr = 6'h0A; dir = 1'b1;
    step(); step(); #1;
    chk("holdoff_busy", 8'(busy), 8'd0);
    req = 1'b0; dir = 1'b0;
    step();

    write_ok("wr", 6'h0A, 8'h55);

    // read of 0x16 returning 0xA5
    req = 1'b1; we = 1'b0; addr = 6'h16;
    step(); req = 1'b0; nxt = 1'b1; #1;
    chk("rd_cmd", data_out, 8'hD6);
    chk("rd_cmd_oe", 8'(data_oe), 8'd1);
    step(); nxt = 1'b0; dir = 1'b1; #1;
    chk("rd_turn_oe", 8'(data_oe), 8'd0);
    step(); data_in = 8'hA5; #1;
    step(); dir = 1'b0; data_in = 8'h00; #1;
    chk("rd_rdata", rdata, 8'hA5);
    step(); #1;
    chk("rd_ack", 8'(ack), 8'd1);
    chk("rd_err", 8'(err), 8'd0);
    step(); #1;
    chk("rd_idle", 8'(busy), 8'd0);

    // PHY takes the bus during write data, then releases it
    req = 1'b1; we = 1'b1; addr = 6'h0A; wdata = 8'h3C;
    step(); req = 1'b0; nxt = 1'b1; #1;
    chk("ab_cmd", data_out, 8'h8A);
    step(); nxt = 1'b0; dir = 1'b1; #1;
    chk("ab_oe_forced", 8'(data_oe), 8'd0);
    chk("ab_data_forced", data_out, 8'h00);
    step(); dir = 1'b0; #1;
    chk("ab_abort_busy", 8'(busy), 8'd1);
    chk("ab_abort_oe", 8'(data_oe), 8'd0);
    step(); nxt = 1'b1; #1;
    chk("ab_recmd", data_out, 8'h8A);
    step(); #1;
    chk("ab_wdata", data_out, 8'h3C);
    step(); nxt = 1'b0; #1;
    chk("ab_stp", 8'(stp), 8'd1);
    step(); #1;
    chk("ab_ack", 8'(ack), 8'd1);
    chk("ab_err", 8'(err), 8'd0);
    step();

    // four aborted attempts exhaust RETRY_MAX=3
    req = 1'b1; we = 1'b1; addr = 6'h01; wdata = 8'h02;
    step(); req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dir = 1'b1; #1;
      chk("rt_oe", 8'(data_oe), 8'd0);
      chk("rt_stp_cmd", 8'(stp), 8'd0);
      chk("rt_noack", 8'(ack), 8'd0);
      step(); dir = 1'b0; #1;
      chk("rt_stp_abort", 8'(stp), 8'd0);
      step();
    end
    #1;
    chk("rt_ack", 8'(ack), 8'd1);
    chk("rt_err", 8'(err), 8'd1);
    chk("rt_stp_done", 8'(stp), 8'd0);
    step(); #1;
    chk("rt_idle", 8'(busy), 8'd0);

    // read with nxt stuck low times out after 16 busy cycles
    req = 1'b1; we = 1'b0; addr = 6'h20;
    step(); req = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      chk("tmo_busy", 8'(busy), 8'd1);
      chk("tmo_noack", 8'(ack), 8'd0);
      step();
    end
    #1;
    chk("tmo_ack", 8'(ack), 8'd1);
    chk("tmo_err", 8'(err), 8'd1);
    step(); #1;
    chk("tmo_oe", 8'(data_oe), 8'd0);
    chk("tmo_idle", 8'(busy), 8'd0);

    // reset in WR_DATA abandons the write
    req = 1'b1; we = 1'b1; addr = 6'h0A; wdata = 8'h55;
    step(); req = 1'b0; nxt = 1'b1; #1;
    step(); nxt = 1'b0; #1;
    chk("mr_in_wdata", data_out, 8'h55);
    rst = 1'b1; #1;
    chk_idle_outputs("mr");
    chk("mr_rdata", rdata, 8'h00);
    step(); #1;
    chk("mr_noack1", 8'(ack), 8'd0);
    step(); #1;
    chk("mr_noack2", 8'(ack), 8'd0);
    rst = 1'b0;
    step();
    write_ok("mr_wr", 6'h0A, 8'h55);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
